// File: rtl/cv32e41p_apu_pkg.sv
// Shared constants and writeback-entry type for the APU writeback buffer.
package cv32e41p_apu_pkg;

   localparam int unsigned APU_ADDR_WIDTH = 6;
   localparam int unsigned APU_NFLAGS     = 5;

   typedef struct packed {
      logic [APU_ADDR_WIDTH-1:0] waddr;
      logic [31:0]               result;
      logic [APU_NFLAGS-1:0]     flags;
   } apu_wb_entry_t;

endpackage

// File: rtl/cv32e41p_apu_fifo.sv
// Synchronous FIFO with wrap-around pointers and an explicit occupancy count.
module cv32e41p_apu_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 2
) (
   input  logic                       clk_i,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           wdata,
   output logic [WIDTH-1:0]           rdata,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       empty
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH+1);

   if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_chk
      $error("cv32e41p_apu_fifo: DEPTH must be a power of two and at least 2");
   end

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wptr_q, rptr_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             do_pop;

   assign do_pop = pop & (cnt_q != '0);

   always_comb begin
      cnt_d = cnt_q;
      if (push && !do_pop) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else if (!push && do_pop) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         if (push) begin
            mem_q[wptr_q] <= wdata;
            wptr_q        <= wptr_q + PTR_W'(1);
         end
         if (do_pop) begin
            rptr_q <= rptr_q + PTR_W'(1);
         end
         cnt_q <= cnt_d;
      end
   end

   assign rdata = mem_q[rptr_q];
   assign count = cnt_q;
   assign full  = (cnt_q == CNT_W'(DEPTH));
   assign empty = (cnt_q == '0);

`ifndef SYNTHESIS
   a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_n) push |-> !full);
`endif

endmodule

// File: rtl/cv32e41p_apu_wb_buffer.sv
// Pairs granted APU destinations with in-order results and buffers them for write port B.
module cv32e41p_apu_wb_buffer
   import cv32e41p_apu_pkg::*;
#(
   parameter int unsigned DEPTH      = 2,
   parameter int unsigned ADDR_WIDTH = APU_ADDR_WIDTH,
   parameter int unsigned NFLAGS     = APU_NFLAGS
) (
   input  logic                  clk_i,
   input  logic                  rst_n,
   input  logic                  apu_req_i,
   input  logic [ADDR_WIDTH-1:0] apu_waddr_req_i,
   output logic                  apu_req_o,
   input  logic                  apu_gnt_i,
   output logic                  apu_stall_o,
   input  logic                  apu_rvalid_i,
   input  logic [31:0]           apu_result_i,
   input  logic [NFLAGS-1:0]     apu_flags_i,
   input  logic                  wb_stall_i,
   output logic                  apu_valid_o,
   output logic [ADDR_WIDTH-1:0] apu_waddr_o,
   output logic [31:0]           apu_result_o,
   output logic [NFLAGS-1:0]     fflags_o,
   output logic                  fflags_we_o,
   output logic                  busy_o,
   output logic                  err_o
);

   localparam int unsigned CNT_W = $clog2(DEPTH+1);
   localparam logic [CNT_W:0] DEPTH_L = DEPTH[CNT_W:0];

   if ((ADDR_WIDTH != APU_ADDR_WIDTH) || (NFLAGS != APU_NFLAGS)) begin : g_width_chk
      $error("cv32e41p_apu_wb_buffer: widths must match cv32e41p_apu_pkg");
   end

   logic [ADDR_WIDTH-1:0] pend_head;
   logic [CNT_W-1:0]      pend_cnt, wb_cnt;
   logic                  pend_full, pend_empty, wb_full, wb_empty;
   logic                  credit_ok, issue, resp_ok, wb_pop;
   logic [CNT_W:0]        inflight;
   apu_wb_entry_t         wb_wdata, wb_head;
   logic                  err_q;

   // Credit uses registered counts only, so a slot freed this cycle is usable next cycle.
   assign inflight  = {1'b0, pend_cnt} + {1'b0, wb_cnt};
   assign credit_ok = (inflight < DEPTH_L);

   assign apu_req_o   = rst_n & apu_req_i & credit_ok;
   assign apu_stall_o = rst_n & apu_req_i & ~credit_ok;

   assign issue   = apu_req_o & apu_gnt_i;
   assign resp_ok = apu_rvalid_i & ~pend_empty;
   assign wb_pop  = apu_valid_o;

   assign wb_wdata = '{waddr: pend_head, result: apu_result_i, flags: apu_flags_i};

   cv32e41p_apu_fifo #(
      .WIDTH (ADDR_WIDTH),
      .DEPTH (DEPTH)
   ) u_pend_fifo (
      .clk_i (clk_i),
      .rst_n (rst_n),
      .push  (issue),
      .pop   (resp_ok),
      .wdata (apu_waddr_req_i),
      .rdata (pend_head),
      .count (pend_cnt),
      .full  (pend_full),
      .empty (pend_empty)
   );

   cv32e41p_apu_fifo #(
      .WIDTH ($bits(apu_wb_entry_t)),
      .DEPTH (DEPTH)
   ) u_wb_fifo (
      .clk_i (clk_i),
      .rst_n (rst_n),
      .push  (resp_ok),
      .pop   (wb_pop),
      .wdata (wb_wdata),
      .rdata (wb_head),
      .count (wb_cnt),
      .full  (wb_full),
      .empty (wb_empty)
   );

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else if (apu_rvalid_i && pend_empty) begin
         err_q <= 1'b1;
      end
   end

   assign apu_valid_o  = ~wb_empty & ~wb_stall_i;
   assign apu_waddr_o  = apu_valid_o ? wb_head.waddr  : '0;
   assign apu_result_o = apu_valid_o ? wb_head.result : '0;
   assign fflags_o     = apu_valid_o ? wb_head.flags  : '0;
   assign fflags_we_o  = apu_valid_o;
   assign busy_o       = ~pend_empty | ~wb_empty;
   assign err_o        = err_q;

`ifndef SYNTHESIS
   a_gnt_with_req: assert property (@(posedge clk_i) disable iff (!rst_n)
      apu_gnt_i |-> apu_req_o);
   a_pend_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_n)
      issue |-> !pend_full);
   a_wb_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_n)
      resp_ok |-> (!wb_full || wb_pop));
`ifdef CV32E41P_APU_LEGAL_TRAFFIC
   a_no_err: assert property (@(posedge clk_i) disable iff (!rst_n) !err_o);
`endif
`endif

endmodule

// File: tb/tb_cv32e41p_apu_wb_buffer.sv
// Directed vector table plus hand-written sequences for the APU writeback buffer.
module tb_cv32e41p_apu_wb_buffer;

   logic        clk_i = 1'b0;
   logic        rst_n;
   logic        apu_req_i;
   logic [5:0]  apu_waddr_req_i;
   logic        apu_req_o;
   logic        apu_gnt_i;
   logic        apu_stall_o;
   logic        apu_rvalid_i;
   logic [31:0] apu_result_i;
   logic [4:0]  apu_flags_i;
   logic        wb_stall_i;
   logic        apu_valid_o;
   logic [5:0]  apu_waddr_o;
   logic [31:0] apu_result_o;
   logic [4:0]  fflags_o;
   logic        fflags_we_o;
   logic        busy_o;
   logic        err_o;

   int checks = 0;
   int errors = 0;

   always #5 clk_i = ~clk_i;

   cv32e41p_apu_wb_buffer #(
      .DEPTH      (2),
      .ADDR_WIDTH (6),
      .NFLAGS     (5)
   ) dut (
      .clk_i           (clk_i),
      .rst_n           (rst_n),
      .apu_req_i       (apu_req_i),
      .apu_waddr_req_i (apu_waddr_req_i),
      .apu_req_o       (apu_req_o),
      .apu_gnt_i       (apu_gnt_i),
      .apu_stall_o     (apu_stall_o),
      .apu_rvalid_i    (apu_rvalid_i),
      .apu_result_i    (apu_result_i),
      .apu_flags_i     (apu_flags_i),
      .wb_stall_i      (wb_stall_i),
      .apu_valid_o     (apu_valid_o),
      .apu_waddr_o     (apu_waddr_o),
      .apu_result_o    (apu_result_o),
      .fflags_o        (fflags_o),
      .fflags_we_o     (fflags_we_o),
      .busy_o          (busy_o),
      .err_o           (err_o)
   );

   typedef struct {
      logic        req;
      logic [5:0]  waddr;
      logic        gnt;
      logic        rvalid;
      logic [31:0] result;
      logic [4:0]  flags;
      logic        stall;
      logic        e_req;
      logic        e_stall;
      logic        e_valid;
      logic [5:0]  e_waddr;
      logic [31:0] e_result;
      logic [4:0]  e_flags;
      logic        e_busy;
   } vec_t;

   localparam int NV = 25;
   vec_t vecs [NV];

   function automatic vec_t row(input logic req, input logic [5:0] waddr, input logic gnt,
                                input logic rvalid, input logic [31:0] result,
                                input logic [4:0] flags, input logic stall,
                                input logic e_req, input logic e_stall, input logic e_valid,
                                input logic [5:0] e_waddr, input logic [31:0] e_result,
                                input logic [4:0] e_flags, input logic e_busy);
      vec_t v;
      v.req = req; v.waddr = waddr; v.gnt = gnt; v.rvalid = rvalid; v.result = result;
      v.flags = flags; v.stall = stall; v.e_req = e_req; v.e_stall = e_stall;
      v.e_valid = e_valid; v.e_waddr = e_waddr; v.e_result = e_result; v.e_flags = e_flags;
      v.e_busy = e_busy;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      apu_req_i = 1'b0; apu_waddr_req_i = 6'h00; apu_gnt_i = 1'b0; apu_rvalid_i = 1'b0;
      apu_result_i = 32'h0; apu_flags_i = 5'h0; wb_stall_i = 1'b0;
   endtask

   task automatic apply(input vec_t v, input int idx);
      @(negedge clk_i);
      apu_req_i = v.req; apu_waddr_req_i = v.waddr; apu_gnt_i = v.gnt;
      apu_rvalid_i = v.rvalid; apu_result_i = v.result; apu_flags_i = v.flags;
      wb_stall_i = v.stall;
      #1;
      chk($sformatf("v%0d.req_o", idx),    32'(apu_req_o),    32'(v.e_req));
      chk($sformatf("v%0d.stall_o", idx),  32'(apu_stall_o),  32'(v.e_stall));
      chk($sformatf("v%0d.valid_o", idx),  32'(apu_valid_o),  32'(v.e_valid));
      chk($sformatf("v%0d.waddr_o", idx),  32'(apu_waddr_o),  32'(v.e_waddr));
      chk($sformatf("v%0d.result_o", idx), apu_result_o,      v.e_result);
      chk($sformatf("v%0d.fflags_o", idx), 32'(fflags_o),     32'(v.e_flags));
      chk($sformatf("v%0d.fflags_we", idx), 32'(fflags_we_o), 32'(v.e_valid));
      chk($sformatf("v%0d.busy_o", idx),   32'(busy_o),       32'(v.e_busy));
      chk($sformatf("v%0d.err_o", idx),    32'(err_o),        32'(1'b0));
   endtask

   task automatic run_random();
      logic [5:0]  pq_addr [$];
      logic [31:0] pq_res  [$];
      logic [4:0]  pq_flg  [$];
      int          pq_due  [$];
      logic [5:0]  ex_addr [$];
      logic [31:0] ex_res  [$];
      logic [4:0]  ex_flg  [$];
      int issued = 0;
      int written = 0;
      int cyc = 0;
      while (written < 100 && cyc < 3000) begin
         @(negedge clk_i);
         cyc++;
         wb_stall_i   = ($urandom_range(0, 7) == 0);
         apu_rvalid_i = 1'b0;
         if (pq_addr.size() > 0 && cyc >= pq_due[0]) begin
            apu_rvalid_i = 1'b1;
            apu_result_i = pq_res[0];
            apu_flags_i  = pq_flg[0];
            void'(pq_addr.pop_front()); void'(pq_res.pop_front());
            void'(pq_flg.pop_front());  void'(pq_due.pop_front());
         end
         apu_req_i       = (issued < 100) && ($urandom_range(0, 3) != 0);
         apu_waddr_req_i = 6'($urandom);
         #1;
         apu_gnt_i = apu_req_o & ($urandom_range(0, 3) != 0);
         if (apu_req_o && apu_gnt_i) begin
            logic [31:0] r;
            logic [4:0]  f;
            r = $urandom;
            f = 5'($urandom);
            pq_addr.push_back(apu_waddr_req_i); pq_res.push_back(r); pq_flg.push_back(f);
            pq_due.push_back(cyc + $urandom_range(1, 4));
            ex_addr.push_back(apu_waddr_req_i); ex_res.push_back(r); ex_flg.push_back(f);
            issued++;
         end
         if (apu_valid_o) begin
            if (ex_addr.size() == 0) begin
               chk("rand_spurious_wb", 32'(1), 32'(0));
            end else begin
               chk($sformatf("rand_waddr[%0d]", written), 32'(apu_waddr_o), 32'(ex_addr[0]));
               chk($sformatf("rand_result[%0d]", written), apu_result_o, ex_res[0]);
               chk($sformatf("rand_flags[%0d]", written), 32'(fflags_o), 32'(ex_flg[0]));
               void'(ex_addr.pop_front()); void'(ex_res.pop_front());
               void'(ex_flg.pop_front());
            end
            written++;
         end
      end
      idle_inputs();
      chk("rand_written", 32'(written), 32'(100));
      @(negedge clk_i);
      #1;
      chk("rand_busy_end", 32'(busy_o), 32'(0));
      chk("rand_err", 32'(err_o), 32'(0));
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state, with a request pending to show it is not forwarded.
      idle_inputs();
      apu_req_i = 1'b1;
      rst_n = 1'b0;
      #12;
      chk("rst_req_o", 32'(apu_req_o), 32'(0));
      chk("rst_stall_o", 32'(apu_stall_o), 32'(0));
      chk("rst_valid_o", 32'(apu_valid_o), 32'(0));
      chk("rst_busy_o", 32'(busy_o), 32'(0));
      chk("rst_err_o", 32'(err_o), 32'(0));
      @(negedge clk_i);
      idle_inputs();
      rst_n = 1'b1;

      // Single op, credit limit, write-port stall.
      vecs[0]  = row(1, 6'h25, 1, 0, 32'h0, 5'h00, 0,  1, 0, 0, 6'h00, 32'h0, 5'h00, 0);
      vecs[1]  = row(0, 6'h00, 0, 0, 32'h0, 5'h00, 0,  0, 0, 0, 6'h00, 32'h0, 5'h00, 1);
      vecs[2]  = row(0, 6'h00, 0, 0, 32'h0, 5'h00, 0,  0, 0, 0, 6'h00, 32'h0, 5'h00, 1);
      vecs[3]  = row(0, 6'h00, 0, 1, 32'h3F800000, 5'h01, 0,
                     0, 0, 0, 6'h00, 32'h0, 5'h00, 1);
      vecs[4]  = row(0, 6'h00, 0, 0, 32'h0, 5'h00, 0,
                     0, 0, 1, 6'h25, 32'h3F800000, 5'h01, 1);
      vecs[5]  = row(0, 6'h00, 0, 0, 32'h0, 5'h00, 0,  0, 0, 0, 6'h00, 32'h0, 5'h00, 0);
      vecs[6]  = row(1, 6'h01, 1, 0, 32'h0, 5'h00, 0,  1, 0, 0, 6'h00, 32'h0, 5'h00, 0);
      vecs[7]  = row(1, 6'h02, 1, 0, 32'h0, 5'h00, 0,  1, 0, 0, 6'h00, 32'h0, 5'h00, 1);
      vecs[8]  = row(1, 6'h03, 0, 0, 32'h0, 5'h00, 0,  0, 1, 0, 6'h00, 32'h0, 5'h00, 1);
      vecs[9]  = row(1, 6'h03, 0, 1, 32'h11, 5'h02, 0, 0, 1, 0, 6'h00, 32'h0, 5'h00, 1);
      vecs[10] = row(1, 6'h03, 0, 0, 32'h0, 5'h00, 0,  0, 1, 1, 6'h01, 32'h11, 5'h02, 1);
      vecs[11] = row(1, 6'h03, 1, 0, 32'h0, 5'h00, 0,  1, 0, 0, 6'h00, 32'h0, 5'h00, 1);
      vecs[12] = row(0, 6'h00, 0, 1, 32'h22, 5'h04, 0, 0, 0, 0, 6'h00, 32'h0, 5'h00, 1);
      vecs[13] = row(0, 6'h00, 0, 1, 32'h33, 5'h08, 0, 0, 0, 1, 6'h02, 32'h22, 5'h04, 1);
      vecs[14] = row(0, 6'h00, 0, 0, 32'h0, 5'h00, 0,  0, 0, 1, 6'h03, 32'h33, 5'h08, 1);
      vecs[15] = row(0, 6'h00, 0, 0, 32'h0, 5'h00, 0,  0, 0, 0, 6'h00, 32'h0, 5'h00, 0);
      vecs[16] = row(1, 6'h03, 1, 0, 32'h0, 5'h00, 0,  1, 0, 0, 6'h00, 32'h0, 5'h00, 0);
      vecs[17] = row(1, 6'h24, 1, 0, 32'h0, 5'h00, 0,  1, 0, 0, 6'h00, 32'h0, 5'h00, 1);
      vecs[18] = row(0, 6'h00, 0, 1, 32'hAAAA0001, 5'h10, 1,
                     0, 0, 0, 6'h00, 32'h0, 5'h00, 1);
      vecs[19] = row(0, 6'h00, 0, 1, 32'hBBBB0002, 5'h03, 1,
                     0, 0, 0, 6'h00, 32'h0, 5'h00, 1);
      vecs[20] = row(0, 6'h00, 0, 0, 32'h0, 5'h00, 1,  0, 0, 0, 6'h00, 32'h0, 5'h00, 1);
      vecs[21] = row(1, 6'h3F, 0, 0, 32'h0, 5'h00, 1,  0, 1, 0, 6'h00, 32'h0, 5'h00, 1);
      vecs[22] = row(0, 6'h00, 0, 0, 32'h0, 5'h00, 0,
                     0, 0, 1, 6'h03, 32'hAAAA0001, 5'h10, 1);
      vecs[23] = row(0, 6'h00, 0, 0, 32'h0, 5'h00, 0,
                     0, 0, 1, 6'h24, 32'hBBBB0002, 5'h03, 1);
      vecs[24] = row(0, 6'h00, 0, 0, 32'h0, 5'h00, 0,  0, 0, 0, 6'h00, 32'h0, 5'h00, 0);
      for (int i = 0; i < NV; i++) begin
         apply(vecs[i], i);
      end

      // Concurrent issue/response/pop with random latency against a scoreboard.
      run_random();

      // Response with nothing pending.
      @(negedge clk_i);
      idle_inputs();
      #1;
      chk("perr_before", 32'(err_o), 32'(0));
      @(negedge clk_i);
      apu_rvalid_i = 1'b1;
      apu_result_i = 32'hDEADBEEF;
      #1;
      chk("perr_no_comb_valid", 32'(apu_valid_o), 32'(0));
      @(negedge clk_i);
      apu_rvalid_i = 1'b0;
      #1;
      chk("perr_err_set", 32'(err_o), 32'(1));
      chk("perr_no_wb", 32'(apu_valid_o), 32'(0));
      chk("perr_busy", 32'(busy_o), 32'(0));
      repeat (3) @(negedge clk_i);
      #1;
      chk("perr_sticky", 32'(err_o), 32'(1));

      // Asynchronous reset with one pending and one buffered entry.
      @(negedge clk_i);
      apu_req_i = 1'b1; apu_waddr_req_i = 6'h05; apu_gnt_i = 1'b1;
      @(negedge clk_i);
      apu_waddr_req_i = 6'h06;
      @(negedge clk_i);
      idle_inputs();
      apu_rvalid_i = 1'b1; apu_result_i = 32'h55; apu_flags_i = 5'h1F;
      @(negedge clk_i);
      idle_inputs();
      #1;
      chk("mrst_pre_valid", 32'(apu_valid_o), 32'(1));
      chk("mrst_pre_waddr", 32'(apu_waddr_o), 32'(6'h05));
      apu_req_i = 1'b1;
      #1;
      rst_n = 1'b0;
      #1;
      chk("mrst_valid", 32'(apu_valid_o), 32'(0));
      chk("mrst_waddr", 32'(apu_waddr_o), 32'(0));
      chk("mrst_result", apu_result_o, 32'h0);
      chk("mrst_fflags", 32'(fflags_o), 32'(0));
      chk("mrst_fflags_we", 32'(fflags_we_o), 32'(0));
      chk("mrst_busy", 32'(busy_o), 32'(0));
      chk("mrst_err", 32'(err_o), 32'(0));
      chk("mrst_req_o", 32'(apu_req_o), 32'(0));
      repeat (2) @(negedge clk_i);
      idle_inputs();
      rst_n = 1'b1;
      #1;
      chk("mrst_post_busy", 32'(busy_o), 32'(0));
      @(negedge clk_i);
      #1;
      chk("mrst_post_valid", 32'(apu_valid_o), 32'(0));
      apu_rvalid_i = 1'b1;
      @(negedge clk_i);
      apu_rvalid_i = 1'b0;
      #1;
      chk("mrst_stale_err", 32'(err_o), 32'(1));
      chk("mrst_stale_no_wb", 32'(apu_valid_o), 32'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cv32e41p_apu_wb_buffer.md
Name: cv32e41p_apu_wb_buffer

Overview:
- Sits between the core's APU issue/response interface and register-file write port B.
- Records the destination address of every granted APU request and pairs it, in order, with the returning result.
- Buffers completed results until the write port is free, then presents one write per cycle as apu_valid_o/apu_waddr_o/apu_result_o. The APU tracer and the regfile consume this output.
- Enforces a credit limit so the APU, which has no response backpressure, can never overflow the buffer.

Parameters:
- DEPTH, 2, maximum APU operations in flight: issued-but-unanswered plus answered-but-not-written-back.
- ADDR_WIDTH, 6, register address width; bit 5 set selects the FP register file.
- NFLAGS, 5, width of APU status flags (fflags).

Ports:
- clk_i  input  1  core clock
- rst_n  input  1  asynchronous active-low reset
- apu_req_i  input  1  EX stage requests an APU operation
- apu_waddr_req_i  input  ADDR_WIDTH  destination register of the requested operation
- apu_req_o  output  1  request forwarded to APU
- apu_gnt_i  input  1  APU grant
- apu_stall_o  output  1  credit exhausted; EX must hold
- apu_rvalid_i  input  1  APU result valid (no ready)
- apu_result_i  input  32  APU result
- apu_flags_i  input  NFLAGS  APU status flags of this result
- wb_stall_i  input  1  write port B taken by a higher-priority writer this cycle
- apu_valid_o  output  1  writeback valid
- apu_waddr_o  output  ADDR_WIDTH  writeback address
- apu_result_o  output  32  writeback data
- fflags_o  output  NFLAGS  flags of the entry written back this cycle
- fflags_we_o  output  1  fflags_o valid
- busy_o  output  1  any operation in flight
- err_o  output  1  sticky protocol error: response with no pending request

Behaviour:
- Reset: async on rst_n low. Both FIFOs are emptied, counters cleared, err_o=0. All outputs are 0 during and after reset. Reset mid-operation drops all in-flight entries; no writeback is issued for them.
- Credit: credit_ok = (pend_cnt + wb_cnt) < DEPTH, computed from registered counts only. Credit freed in cycle N is usable in N+1.
- Request path:
  - apu_req_o = apu_req_i & credit_ok.
  - apu_stall_o = apu_req_i & ~credit_ok.
- Issue: apu_req_o & apu_gnt_i at edge N pushes apu_waddr_req_i into the pending FIFO (depth DEPTH).
- Response: apu_rvalid_i at edge N pops the pending head and pushes {waddr, result, flags} into the WB FIFO (depth DEPTH) in the same edge.
  - rvalid with pending empty: no push, err_o set to 1 and held until reset.
- Writeback outputs:
  - apu_valid_o = (wb_cnt != 0) & ~wb_stall_i.
  - Address, result and flags come from the WB head; drive 0 when apu_valid_o=0.
  - fflags_we_o = apu_valid_o.
  - Head pops on any edge where apu_valid_o=1.
- Latency: rvalid at edge N gives apu_valid_o in cycle N+1 at the earliest. No combinational rvalid-to-valid path.
- Stall: while wb_stall_i=1 the head holds, outputs are 0, and responses keep being accepted; the credit rule guarantees no overflow.
- Simultaneous events:
  - Issue, response and pop on the same edge each update their own pointers.
  - Counts become pend_cnt+issue-resp and wb_cnt+resp-pop.
- Ordering: strictly in-order; the APU returns results in issue order.
- busy_o = (pend_cnt != 0) | (wb_cnt != 0).
- Pointers: log2(DEPTH)-bit wrap-around, with a separate count register per FIFO. DEPTH must be a power of two (elaboration assertion).
- Assertions:
  - No push to a full FIFO.
  - apu_gnt_i only while apu_req_o.
  - err_o never set in legal traffic.

Decomposition:
- Package cv32e41p_apu_pkg holds:
  - APU_ADDR_WIDTH and APU_NFLAGS constants.
  - The wb entry struct {waddr, result, flags}.
- One sub-module, cv32e41p_apu_fifo: parameterised-width synchronous FIFO with count, full and empty. Instantiated twice, once for the pending addresses and once for the WB entries.

Test Plan:
- Single op: req with waddr=0x25, gnt same cycle; rvalid 3 cycles later with result=0x3F800000 and flags=0x01 -> apu_valid_o one cycle after rvalid, waddr=0x25, result=0x3F800000, fflags_we_o=1, fflags_o=0x01; busy_o then drops to 0.
- Credit: DEPTH=2, two ops granted with no response -> third req sees apu_req_o=0 and apu_stall_o=1. After the first writeback pops, req is forwarded in the next cycle, not the same one.
- Write-port stall: two back-to-back responses (waddr 0x03, 0x24) while wb_stall_i=1 for 4 cycles -> no apu_valid_o during the stall, then 0x03 and 0x24 in consecutive cycles, in order.
- Concurrency: issue, rvalid and pop on the same edge at steady state -> counts unchanged, no dropped or duplicated writeback over 100 random-latency ops; a scoreboard matches the address sequence.
- Protocol error: rvalid with nothing pending -> err_o=1, sticky, and no writeback.
- Reset mid-operation: rst_n low with 2 entries in flight -> all outputs 0 immediately (async). After release busy_o=0, and a stale rvalid sets err_o.
